// File: rtl/pace_output_stage.sv
// pace_output_stage
//   Turns a single-cycle pace request from the pacemaker controller into a
//   charge-balanced biphasic stimulus: cathodic drive, interphase gap, anodic
//   recharge (longer and weaker by ANOD_SHIFT), then a sense-blank tail.
//
// Ports
//   clk          clock (board clock, one count per cycle)
//   rst          synchronous active-high reset; every output goes to 0
//   enable       armed; when low new requests are refused
//   pace_req     single-cycle pace request
//   amp_code     requested cathodic amplitude, sampled at accept
//   stim_cath    cathodic switch drive
//   stim_anod    anodic switch drive
//   dac_code     amplitude for the current phase, 0 outside phases
//   sense_blank  high from the first stimulus cycle to the end of the tail
//   busy         stage not idle (same timing as sense_blank)
//   req_dropped  one-cycle pulse for every refused request
//   pulse_count  accepted stimuli, saturating at 65535
//
// Every output is a register fed from the FSM state of the previous cycle,
// so a request sampled at edge N shows up on the outputs from edge N+1.
module pace_output_stage #(
  parameter int CATH_CYCLES  = 40,
  parameter int GAP_CYCLES   = 5,
  parameter int ANOD_SHIFT   = 2,
  parameter int BLANK_CYCLES = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pace_req,
  input  logic [7:0]  amp_code,
  output logic        stim_cath,
  output logic        stim_anod,
  output logic [7:0]  dac_code,
  output logic        sense_blank,
  output logic        busy,
  output logic        req_dropped,
  output logic [15:0] pulse_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CATH = 3'd1,
    GAP  = 3'd2,
    ANOD = 3'd3,
    TAIL = 3'd4
  } state_t;

  // The phase counter holds "cycles remaining minus one" and is reloaded on
  // every state entry. The anodic length CATH_CYCLES<<ANOD_SHIFT must stay
  // at or below 4096 so its reload value fits the 12-bit counter.
  localparam int ANOD_CYCLES = CATH_CYCLES << ANOD_SHIFT;
  localparam logic [11:0] CATH_LAST  = 12'(CATH_CYCLES - 1);
  localparam logic [11:0] GAP_LAST   = 12'(GAP_CYCLES - 1);
  localparam logic [11:0] ANOD_LAST  = 12'(ANOD_CYCLES - 1);
  localparam logic [11:0] BLANK_LAST = 12'(BLANK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  amp_q, amp_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        drop_q, drop_d;
  logic        accept;
  logic        last;

  logic        stim_cath_d, stim_anod_d, blank_d;
  logic [7:0]  dac_d;

  assign accept = (state_q == IDLE) && pace_req && enable && (amp_code != 8'd0);
  assign last   = (cnt_q == 12'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 12'd1;
    case (state_q)
      IDLE: begin
        cnt_d = 12'd0;
        if (accept) begin
          state_d = CATH;
          cnt_d   = CATH_LAST;
        end
      end
      CATH: if (last) begin
        state_d = GAP;
        cnt_d   = GAP_LAST;
      end
      GAP: if (last) begin
        state_d = ANOD;
        cnt_d   = ANOD_LAST;
      end
      ANOD: if (last) begin
        state_d = TAIL;
        cnt_d   = BLANK_LAST;
      end
      TAIL: if (last) begin
        state_d = IDLE;
        cnt_d   = 12'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 12'd0;
      end
    endcase
  end

  // Accept bookkeeping: amplitude latch, saturating stimulus count, refusal flag
  always_comb begin
    amp_d  = amp_q;
    pcnt_d = pcnt_q;
    drop_d = pace_req && !accept;
    if (accept) begin
      amp_d = amp_code;
      if (pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
    end
  end

  // Output decode from the current state
  always_comb begin
    stim_cath_d = 1'b0;
    stim_anod_d = 1'b0;
    dac_d       = 8'd0;
    blank_d     = (state_q != IDLE);
    case (state_q)
      CATH: begin
        stim_cath_d = 1'b1;
        dac_d       = amp_q;
      end
      ANOD: begin
        stim_anod_d = 1'b1;
        dac_d       = amp_q >> ANOD_SHIFT;
      end
      default: ;
    endcase
  end

  // The amplitude latch is only read while a stimulus is running, and a
  // stimulus can only start through an accept that reloads it.
  always_ff @(posedge clk) begin
    amp_q <= amp_d;
  end

  // Registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q      <= 16'd0;
      drop_q      <= 1'b0;
      stim_cath   <= 1'b0;
      stim_anod   <= 1'b0;
      dac_code    <= 8'd0;
      sense_blank <= 1'b0;
      busy        <= 1'b0;
      req_dropped <= 1'b0;
      pulse_count <= 16'd0;
    end else begin
      pcnt_q      <= pcnt_d;
      drop_q      <= drop_d;
      stim_cath   <= stim_cath_d;
      stim_anod   <= stim_anod_d;
      dac_code    <= dac_d;
      sense_blank <= blank_d;
      busy        <= blank_d;
      req_dropped <= drop_q;
      pulse_count <= pcnt_q;
    end
  end

endmodule

// File: tb/tb_pace_output_stage.sv
// Bench for pace_output_stage with CATH=4, GAP=2, ANOD_SHIFT=1, BLANK=3.
// Cycle k means "just after clock edge k"; a request driven so that edge N
// samples it is called a request at cycle N.
module tb_pace_output_stage;

  localparam int C  = 4;
  localparam int G  = 2;
  localparam int S  = 1;
  localparam int B  = 3;
  localparam int AL = C << S;
  localparam int T  = C + G + AL + B;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pace_req;
  logic [7:0]  amp_code;
  logic        stim_cath, stim_anod, sense_blank, busy, req_dropped;
  logic [7:0]  dac_code;
  logic [15:0] pulse_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state (what the stage holds after the latest edge)
  bit          m_active = 1'b0;
  int          m_start  = 0;
  logic [7:0]  m_amp    = 8'd0;
  int          m_cnt    = 0;
  bit          m_drop   = 1'b0;
  // Expected outputs for the current cycle
  logic        x_cath, x_anod, x_blank, x_busy, x_drop;
  logic [7:0]  x_dac;
  logic [15:0] x_cnt;

  pace_output_stage #(
    .CATH_CYCLES(C),
    .GAP_CYCLES(G),
    .ANOD_SHIFT(S),
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .pace_req(pace_req),
    .amp_code(amp_code),
    .stim_cath(stim_cath),
    .stim_anod(stim_anod),
    .dac_code(dac_code),
    .sense_blank(sense_blank),
    .busy(busy),
    .req_dropped(req_dropped),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endfunction

  // Model + per-cycle compare
  initial begin
    int e, r;
    bit acc;
    forever begin
      @(posedge clk);
      e = cyc + 1;
      x_cath = 0; x_anod = 0; x_blank = 0; x_busy = 0; x_dac = 8'd0;
      if (rst) begin
        x_drop = 0; x_cnt = 16'd0;
        m_active = 0; m_cnt = 0; m_drop = 0;
      end else begin
        if (m_active) begin
          r = (e - 1) - m_start;
          if (r < C) begin
            x_cath = 1; x_dac = m_amp;
          end else if (r >= C + G && r < C + G + AL) begin
            x_anod = 1; x_dac = m_amp >> S;
          end
          x_blank = 1; x_busy = 1;
        end
        x_drop = m_drop;
        x_cnt  = 16'(m_cnt);
        acc = pace_req && !m_active && enable && (amp_code != 8'd0);
        m_drop = pace_req && !acc;
        if (acc) begin
          m_active = 1; m_start = e; m_amp = amp_code;
          if (m_cnt < 65535) m_cnt++;
        end else if (m_active && (e - m_start) >= T) begin
          m_active = 0;
        end
      end
      @(negedge clk);
      check("stim_cath",   stim_cath,   x_cath);
      check("stim_anod",   stim_anod,   x_anod);
      check("dac_code",    dac_code,    x_dac);
      check("sense_blank", sense_blank, x_blank);
      check("busy",        busy,        x_busy);
      check("req_dropped", req_dropped, x_drop);
      check("pulse_count", pulse_count, x_cnt);
      check("switch_overlap", stim_cath & stim_anod, 1'b0);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(input int n, input logic [7:0] a);
    wait_cyc(n - 1);
    pace_req = 1'b1;
    amp_code = a;
    wait_cyc(n);
    pace_req = 1'b0;
    amp_code = 8'($urandom);
  endtask

  task automatic do_reset(output int base);
    rst = 1'b1;
    pace_req = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst = 1'b1; enable = 1'b1; pace_req = 1'b0; amp_code = 8'd0;
    @(posedge clk); #1;
    check("reset_busy", busy, 1'b0);
    check("reset_count", pulse_count, 16'd0);

    // Nominal stimulus, plus a second request while busy
    do_reset(b);
    pulse_req(b + 10, 8'd200);
    wait_cyc(b + 11);
    check("s1_cath_on", stim_cath, 1'b1);
    check("s1_cath_dac", dac_code, 8'd200);
    check("s1_model_dac", x_dac, 8'd200);
    check("s1_blank_on", sense_blank, 1'b1);
    wait_cyc(b + 14);
    check("s1_cath_last", stim_cath, 1'b1);
    wait_cyc(b + 15);
    check("s1_gap_cath", stim_cath, 1'b0);
    check("s1_gap_dac", dac_code, 8'd0);
    wait_cyc(b + 17);
    check("s1_anod_on", stim_anod, 1'b1);
    check("s1_anod_dac", dac_code, 8'd100);
    check("s1_model_anod", x_dac, 8'd100);
    pulse_req(b + 20, 8'd77);
    wait_cyc(b + 21);
    check("s2_dropped", req_dropped, 1'b1);
    check("s2_anod_dac", dac_code, 8'd100);
    wait_cyc(b + 24);
    check("s1_anod_last", stim_anod, 1'b1);
    wait_cyc(b + 25);
    check("s1_tail_anod", stim_anod, 1'b0);
    check("s1_tail_blank", sense_blank, 1'b1);
    wait_cyc(b + 27);
    check("s1_busy_27", busy, 1'b1);
    wait_cyc(b + 28);
    check("s1_idle_28", busy, 1'b0);
    check("s1_count", pulse_count, 16'd1);
    check("s1_model_count", x_cnt, 16'd1);

    // Refusals: disabled, then zero amplitude
    do_reset(b);
    enable = 1'b0;
    pulse_req(b + 5, 8'd50);
    wait_cyc(b + 6);
    check("s3_dis_drop", req_dropped, 1'b1);
    check("s3_dis_busy", busy, 1'b0);
    enable = 1'b1;
    pulse_req(b + 10, 8'd0);
    wait_cyc(b + 11);
    check("s3_zero_drop", req_dropped, 1'b1);
    check("s3_zero_cath", stim_cath, 1'b0);
    check("s3_count", pulse_count, 16'd0);

    // Enable dropped mid-stimulus: stimulus completes
    do_reset(b);
    pulse_req(b + 10, 8'd200);
    wait_cyc(b + 15);
    enable = 1'b0;
    wait_cyc(b + 17);
    check("s4_anod_on", stim_anod, 1'b1);
    check("s4_anod_dac", dac_code, 8'd100);
    wait_cyc(b + 24);
    check("s4_anod_last", stim_anod, 1'b1);
    wait_cyc(b + 28);
    check("s4_idle", busy, 1'b0);
    enable = 1'b1;

    // Reset during the anodic phase
    do_reset(b);
    pulse_req(b + 10, 8'd200);
    wait_cyc(b + 17);
    rst = 1'b1;
    wait_cyc(b + 18);
    rst = 1'b0;
    wait_cyc(b + 19);
    check("s5_rst_anod", stim_anod, 1'b0);
    check("s5_rst_dac", dac_code, 8'd0);
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_count", pulse_count, 16'd0);
    pulse_req(b + 20, 8'd60);
    wait_cyc(b + 21);
    check("s5_cath", stim_cath, 1'b1);
    check("s5_dac", dac_code, 8'd60);

    // Last tail cycle refuses, first idle cycle accepts; held request
    do_reset(b);
    pulse_req(b + 10, 8'd120);
    pulse_req(b + 27, 8'd90);
    pulse_req(b + 28, 8'd90);
    check("s6_tail_drop", req_dropped, 1'b1);
    wait_cyc(b + 29);
    check("s6_cath", stim_cath, 1'b1);
    check("s6_dac", dac_code, 8'd90);
    check("s6_count", pulse_count, 16'd2);
    wait_cyc(b + 34);
    pace_req = 1'b1;
    wait_cyc(b + 37);
    pace_req = 1'b0;
    wait_cyc(b + 38);
    check("s6_held_drop", req_dropped, 1'b1);
    check("s6_held_count", pulse_count, 16'd2);

    // Saturation of the stimulus count
    do_reset(b);
    wait_cyc(b + 2);
    force dut.pcnt_q = 16'd65533;
    m_cnt = 65533;
    #2;
    release dut.pcnt_q;
    pulse_req(b + 5, 8'd10);
    pulse_req(b + 25, 8'd10);
    wait_cyc(b + 26);
    check("s7_count_max", pulse_count, 16'd65535);
    pulse_req(b + 45, 8'd10);
    wait_cyc(b + 46);
    check("s7_count_sat", pulse_count, 16'd65535);
    check("s7_cath", stim_cath, 1'b1);
    check("s7_dac", dac_code, 8'd10);

    // Randomized traffic against the model
    do_reset(b);
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      pace_req = ($urandom_range(0, 5) == 0);
      enable   = ($urandom_range(0, 9) != 0);
      amp_code = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    rst = 1'b0; pace_req = 1'b0;
    repeat (T + 4) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
